// File: rtl/wb_uart.sv
// wb_uart: Wishbone slave UART with RX/TX FIFOs and a level interrupt.
// Register map on ADDR[3:2]: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved.
// Optional feature: define WB_UART_LOOPBACK_EN to add CTRL[1], which routes
// the internal TX line into the RX synchroniser and holds txd high.
module wb_uart #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        STB,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK,
  output logic        INT,
  input  logic        rxd,
  output logic        txd
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int CW  = $clog2(DIV + 1);
  // Counters count down to zero, so a load of N-1 spans N cycles.
  localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Bus decode: every side effect happens on the edge that raises ACK.
  logic       bus_req, ctrl_wr, status_clr;
  logic [1:0] reg_sel;
  assign bus_req    = STB & ~ACK;
  assign reg_sel    = ADDR[3:2];
  assign ctrl_wr    = bus_req & WE & (reg_sel == 2'd2);
  assign status_clr = bus_req & WE & (reg_sel == 2'd1);

  logic unused_bits;
  assign unused_bits = ^{ADDR[31:4], ADDR[1:0], DAT_I[31:8]};

  // FIFOs
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wptr, rx_rptr, rx_level, tx_wptr, tx_rptr;
  logic          rx_empty, rx_full, rx_push, rx_pop, rx_push_req;
  logic          tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]    rx_byte, tx_head;

  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
  assign rx_level = rx_wptr - rx_rptr;
  assign tx_head  = tx_mem[tx_rptr[AW-1:0]];

  // A push into a full FIFO is still accepted when a pop frees a slot that cycle.
  assign rx_pop  = bus_req & ~WE & (reg_sel == 2'd0) & ~rx_empty;
  assign rx_push = rx_push_req & (~rx_full | rx_pop);
  assign tx_push = bus_req & WE & (reg_sel == 2'd0) & (~tx_full | tx_pop);

  // FIFO storage, no reset needed since pointers define validity
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= rx_byte;
    if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= DAT_I[7:0];
  end

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + PW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + PW'(1);
      if (tx_push) tx_wptr <= tx_wptr + PW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + PW'(1);
    end
  end

  // Control and sticky status
  logic ctrl_ie, ctrl_lb, overrun, frame_err, rx_ferr, tx_idle, tx_line, rx_src;
  tx_state_t tx_state, tx_state_n;

  assign tx_idle = tx_empty & (tx_state == TX_IDLE);

`ifdef WB_UART_LOOPBACK_EN
  // Loopback select bit
  always_ff @(posedge clk) begin
    if (rst)          ctrl_lb <= 1'b0;
    else if (ctrl_wr) ctrl_lb <= DAT_I[1];
  end
  assign rx_src = ctrl_lb ? tx_line : rxd;
  assign txd    = ctrl_lb ? 1'b1 : tx_line;
`else
  assign ctrl_lb = 1'b0;
  assign rx_src  = rxd;
  assign txd     = tx_line;
`endif

  // Read mux
  logic [31:0] rd_data, status_word;
  assign status_word = {16'b0, 8'(rx_level), 3'b0, frame_err, overrun, tx_idle, tx_full, rx_empty};
  always_comb begin
    rd_data = 32'b0;
    case (reg_sel)
      2'd0:    if (!rx_empty) rd_data = {24'b0, rx_mem[rx_rptr[AW-1:0]]};
      2'd1:    rd_data = status_word;
      2'd2:    rd_data = {30'b0, ctrl_lb, ctrl_ie};
      default: rd_data = 32'b0;
    endcase
  end

  // Bus response, control register, sticky flags and interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      ACK       <= 1'b0;
      DAT_O     <= 32'b0;
      INT       <= 1'b0;
      ctrl_ie   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ACK   <= bus_req;
      DAT_O <= (bus_req && !WE) ? rd_data : 32'b0;
      INT   <= ctrl_ie & ~rx_empty;
      if (ctrl_wr) ctrl_ie <= DAT_I[0];
      // A hardware set in the same cycle as a clear wins.
      if (rx_push_req && rx_full && !rx_pop) overrun <= 1'b1;
      else if (status_clr && DAT_I[3])       overrun <= 1'b0;
      if (rx_ferr)                           frame_err <= 1'b1;
      else if (status_clr && DAT_I[4])       frame_err <= 1'b0;
    end
  end

  // RX synchroniser plus one extra stage for falling-edge detection
  logic rx_s1, rx_s2, rx_s3;
  always_ff @(posedge clk) begin
    if (rst) {rx_s1, rx_s2, rx_s3} <= 3'b111;
    else begin
      rx_s1 <= rx_src;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_sh, rx_sh_n;
  assign rx_byte = rx_sh;

  // RX state register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
    end
  end

  // RX next state: half-bit to mid start, then one bit time per sample
  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_bit_n    = rx_bit;
    rx_sh_n     = rx_sh;
    rx_push_req = 1'b0;
    rx_ferr     = 1'b0;
    case (rx_state)
      RX_IDLE:
        if (rx_s3 && !rx_s2) begin
          rx_cnt_n   = HALF_LOAD;
          rx_state_n = RX_START;
        end
      RX_START:
        if (rx_cnt == '0) begin
          if (!rx_s2) begin
            rx_cnt_n   = BIT_LOAD;
            rx_bit_n   = 3'd0;
            rx_state_n = RX_DATA;
          end else begin
            rx_state_n = RX_IDLE;
          end
        end else rx_cnt_n = rx_cnt - CW'(1);
      RX_DATA:
        if (rx_cnt == '0) begin
          rx_sh_n  = {rx_s2, rx_sh[7:1]};
          rx_cnt_n = BIT_LOAD;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else rx_cnt_n = rx_cnt - CW'(1);
      RX_STOP:
        if (rx_cnt == '0) begin
          if (rx_s2) rx_push_req = 1'b1;
          else       rx_ferr     = 1'b1;
          rx_state_n = RX_IDLE;
        end else rx_cnt_n = rx_cnt - CW'(1);
      default: rx_state_n = RX_IDLE;
    endcase
  end

  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_sh, tx_sh_n;
  assign tx_line = (tx_state == TX_START) ? 1'b0 :
                   (tx_state == TX_DATA)  ? tx_sh[0] : 1'b1;

  // TX state register
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
    end
  end

  // TX next state: STOP chains straight into START when more data waits
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE:
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_n    = tx_head;
          tx_cnt_n   = BIT_LOAD;
          tx_state_n = TX_START;
        end
      TX_START:
        if (tx_cnt == '0) begin
          tx_cnt_n   = BIT_LOAD;
          tx_bit_n   = 3'd0;
          tx_state_n = TX_DATA;
        end else tx_cnt_n = tx_cnt - CW'(1);
      TX_DATA:
        if (tx_cnt == '0) begin
          tx_cnt_n = BIT_LOAD;
          tx_sh_n  = {1'b0, tx_sh[7:1]};
          if (tx_bit == 3'd7) tx_state_n = TX_STOP;
          else                tx_bit_n   = tx_bit + 3'd1;
        end else tx_cnt_n = tx_cnt - CW'(1);
      TX_STOP:
        if (tx_cnt == '0) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_n    = tx_head;
            tx_cnt_n   = BIT_LOAD;
            tx_state_n = TX_START;
          end else begin
            tx_state_n = TX_IDLE;
          end
        end else tx_cnt_n = tx_cnt - CW'(1);
      default: tx_state_n = TX_IDLE;
    endcase
  end
endmodule

// File: tb/tb_wb_uart.sv
// tb_wb_uart: register vectors, serial frame checks and a queue-based
// reference model for randomised RX/TX traffic on a DIV=16, depth-4 UART.
`timescale 1ns/1ps
module tb_wb_uart;
  localparam int CLK_HZ = 1600;
  localparam int BAUD   = 100;
  localparam int DEPTH  = 4;
  localparam int DIV    = 16;
`ifdef WB_UART_LOOPBACK_EN
  localparam logic [31:0] CTRL_MASK = 32'h3;
`else
  localparam logic [31:0] CTRL_MASK = 32'h1;
`endif

  logic        clk = 1'b0, rst = 1'b1, STB = 1'b0, WE = 1'b0, rxd = 1'b1;
  logic [31:0] ADDR = 32'b0, DAT_I = 32'b0;
  logic [31:0] DAT_O;
  logic        ACK, INT, txd;
  int checks = 0, failures = 0;

  wb_uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .STB(STB), .WE(WE), .ADDR(ADDR), .DAT_I(DAT_I),
    .DAT_O(DAT_O), .ACK(ACK), .INT(INT), .rxd(rxd), .txd(txd)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd);
    STB = 1'b1; WE = we; ADDR = addr; DAT_I = wd;
    tick(1);
    chk("ack", 32'(ACK), 32'd1);
    rd = DAT_O;
    STB = 1'b0; WE = 1'b0;
    tick(1);
  endtask

  task automatic wrreg(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] x;
    bus(1'b1, {28'b0, r, 2'b0}, d, x);
  endtask

  task automatic rdreg(input logic [1:0] r, output logic [31:0] d);
    bus(1'b0, {28'b0, r, 2'b0}, 32'b0, d);
  endtask

  // Drive one serial frame on rxd: start, 8 data LSB-first, given stop level.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin rxd = fr[i]; tick(DIV); end
    rxd = 1'b1;
  endtask

  // Expected STATUS word from the model's view of the RX side (TX idle).
  function automatic logic [31:0] model_status(input int cnt, input logic ov, input logic fe);
    return {16'b0, 8'(cnt), 3'b0, fe, ov, 1'b1, 1'b0, (cnt == 0)};
  endfunction

  // Wait for a start bit, then compare every cycle of the expected line waveform.
  task automatic capture_tx(input logic [7:0] bytes[$], input string name);
    int t, bad_at, f, k;
    logic e;
    t = 0;
    while (txd !== 1'b0 && t < 100) begin tick(1); t++; end
    if (txd !== 1'b0) begin
      chk({name, "_start"}, 32'(txd), 32'd0);
    end else begin
      bad_at = -1;
      for (int i = 0; i < bytes.size() * 10 * DIV; i++) begin
        f = i / (10 * DIV);
        k = (i / DIV) % 10;
        e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : bytes[f][k-1];
        if (txd !== e && bad_at < 0) bad_at = i;
        tick(1);
      end
      if (txd !== 1'b1 && bad_at < 0) bad_at = bytes.size() * 10 * DIV;
      chk({name, "_wave_first_bad_cycle"}, 32'(bad_at), 32'hFFFF_FFFF);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  localparam int NV = 12;
  vec_t tbl [NV];

  initial begin
    logic [31:0] r;
    logic [7:0]  q[$];
    logic [7:0]  txq[$];
    logic [7:0]  txb[6];
    logic [7:0]  b;
    logic        ov, ie;
    int          n, lows;

    tbl[0]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h0000_0005};
    tbl[1]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h0000_0000};
    tbl[2]  = '{1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0};
    tbl[3]  = '{1'b0, 32'h0000_0008, 32'h0,         CTRL_MASK};
    tbl[4]  = '{1'b1, 32'h0000_0008, 32'h0,         32'h0};
    tbl[5]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000};
    tbl[6]  = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 32'h0};
    tbl[7]  = '{1'b0, 32'h0000_000C, 32'h0,         32'h0000_0000};
    tbl[8]  = '{1'b0, 32'hFFFF_FFF4, 32'h0,         32'h0000_0005};
    tbl[9]  = '{1'b1, 32'h0000_0004, 32'h0000_0018, 32'h0};
    tbl[10] = '{1'b0, 32'h0000_0004, 32'h0,         32'h0000_0005};
    tbl[11] = '{1'b0, 32'h0000_0008, 32'h0,         32'h0000_0000};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ack",   32'(ACK), 32'd0);
    chk("rst_dat_o", DAT_O,    32'd0);
    chk("rst_int",   32'(INT), 32'd0);
    chk("rst_txd",   32'(txd), 32'd1);

    for (int i = 0; i < NV; i++) begin
      bus(tbl[i].we, tbl[i].addr, tbl[i].wd, r);
      if (!tbl[i].we) chk($sformatf("vec%0d", i), r, tbl[i].exp);
    end

    // Single TX frame 0xA5
    txq.delete(); txq.push_back(8'hA5);
    fork
      wrreg(2'd0, 32'h0000_00A5);
      capture_tx(txq, "tx_a5");
      begin tick(40); rdreg(2'd1, r); chk("tx_busy_status", r, 32'h0000_0001); end
    join
    rdreg(2'd1, r); chk("tx_done_status", r, 32'h0000_0005);

    // RX 0x3C with interrupt enabled
    wrreg(2'd2, 32'h1);
    chk("int_idle", 32'(INT), 32'd0);
    send_byte(8'h3C, 1'b1);
    chk("int_rise", 32'(INT), 32'd1);
    STB = 1'b1; WE = 1'b0; ADDR = 32'h0;
    tick(1);
    chk("rx3c_ack",  32'(ACK), 32'd1);
    chk("rx3c_data", DAT_O,    32'h0000_003C);
    chk("int_ack",   32'(INT), 32'd1);
    STB = 1'b0;
    tick(1);
    chk("int_fall",  32'(INT), 32'd0);
    rdreg(2'd1, r); chk("rx3c_status", r, 32'h0000_0005);

    // Overrun: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    rdreg(2'd1, r); chk("ovr_status", r, 32'h0000_040C);
    for (int i = 1; i <= 5; i++) begin
      rdreg(2'd0, r); chk($sformatf("ovr_read%0d", i), r, (i <= 4) ? 32'(i) : 32'd0);
    end
    wrreg(2'd1, 32'h08);
    rdreg(2'd1, r); chk("ovr_clear", r, 32'h0000_0005);

    // Framing error, then a short glitch that must be ignored
    send_byte(8'h55, 1'b0);
    tick(5);
    rdreg(2'd1, r); chk("ferr_status", r, 32'h0000_0015);
    rxd = 1'b0; tick(4); rxd = 1'b1; tick(30);
    rdreg(2'd1, r); chk("glitch_status", r, 32'h0000_0015);
    rdreg(2'd0, r); chk("glitch_data", r, 32'h0);
    wrreg(2'd1, 32'h10);
    rdreg(2'd1, r); chk("ferr_clear", r, 32'h0000_0005);

    // Randomised RX bursts against the queue model
    for (int it = 0; it < 3; it++) begin
      q.delete(); ov = 1'b0;
      ie = 1'($urandom_range(0, 1));
      wrreg(2'd2, {31'b0, ie});
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        send_byte(b, 1'b1);
        if (q.size() < DEPTH) q.push_back(b); else ov = 1'b1;
      end
      chk($sformatf("rnd%0d_int", it), 32'(INT), 32'(ie && (q.size() > 0)));
      rdreg(2'd1, r); chk($sformatf("rnd%0d_status", it), r, model_status(q.size(), ov, 1'b0));
      for (int j = 0; j <= n; j++) begin
        rdreg(2'd0, r);
        chk($sformatf("rnd%0d_pop%0d", it, j), r, (q.size() > 0) ? 32'(q.pop_front()) : 32'd0);
      end
      wrreg(2'd1, 32'h18);
    end

    // TX burst: one byte in the shifter plus DEPTH queued, the rest dropped
    txq.delete();
    for (int j = 0; j < 6; j++) begin
      txb[j] = 8'($urandom);
      if (j < DEPTH + 1) txq.push_back(txb[j]);
    end
    fork
      begin
        for (int j = 0; j < 6; j++) wrreg(2'd0, {24'b0, txb[j]});
        rdreg(2'd1, r); chk("tx_full_status", r, 32'h0000_0003);
      end
      capture_tx(txq, "tx_burst");
    join
    rdreg(2'd1, r); chk("tx_burst_idle", r, 32'h0000_0005);

    // Reset in the middle of a frame
    wrreg(2'd0, 32'h0);
    tick(30);
    chk("txd_midframe", 32'(txd), 32'd0);
    rst = 1'b1;
    tick(1);
    chk("txd_after_rst", 32'(txd), 32'd1);
    rst = 1'b0;
    lows = 0;
    repeat (200) begin if (txd !== 1'b1) lows++; tick(1); end
    chk("txd_quiet_after_rst", 32'(lows), 32'd0);
    rdreg(2'd1, r); chk("rst_status", r, 32'h0000_0005);

`ifdef WB_UART_LOOPBACK_EN
    wrreg(2'd2, 32'h3);
    lows = 0;
    fork
      begin wrreg(2'd0, 32'h5A); wrreg(2'd0, 32'hC3); tick(320); end
      repeat (330) begin if (txd !== 1'b1) lows++; tick(1); end
    join
    chk("lb_txd_high", 32'(lows), 32'd0);
    rdreg(2'd1, r); chk("lb_status", r, 32'h0000_0204);
    rdreg(2'd0, r); chk("lb_read0", r, 32'h5A);
    rdreg(2'd0, r); chk("lb_read1", r, 32'hC3);
    wrreg(2'd2, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_uart.md
Name: wb_uart

Overview:
- Wishbone slave UART for the peripheral bus. It sits on one intercon slave slot, next to the keyboard and counter slaves.
- Serialises CPU writes out on TXD and deserialises RXD into a receive FIFO. Drives a level interrupt into the CPU interrupt/cause mux.
- Replaces the interim disk-over-UART path as the host serial channel.

Parameters:
- CLK_HZ, 100000000, frequency of clk in Hz.
- BAUD, 115200, line rate. DIV = CLK_HZ/BAUD, integer-truncated, must be ≥ 4.
- FIFO_DEPTH, 16, entries per RX and TX FIFO. Power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- STB  in  1  bus strobe, slave selected.
- WE  in  1  1 = write, 0 = read.
- ADDR  in  32  byte address. Only ADDR[3:2] decoded.
- DAT_I  in  32  write data.
- DAT_O  out  32  read data, valid while ACK=1.
- ACK  out  1  access acknowledge.
- INT  out  1  level interrupt request.
- rxd  in  1  serial in, asynchronous, idle high.
- txd  out  1  serial out, idle high.

Behaviour:
- Reset values: ACK=0, DAT_O=0, INT=0, txd=1, both FIFOs empty, CTRL=0, sticky flags=0, RX/TX FSMs IDLE.
- Reset mid-frame aborts the frame and forces txd=1 on the next cycle.
- Handshake: ACK <= STB & ~ACK, so there is one-cycle latency and a one-cycle pulse. Held STB yields alternating ACK.
- All register side effects (push, pop, clear) commit only in the cycle ACK is driven 1, using ADDR/WE/DAT_I sampled on the preceding edge.
- Register map, ADDR[3:2]:
  - 0 DATA:
    - Read pops the RX FIFO and returns {24'b0, byte}. If RX is empty it returns 0 and does not pop.
    - Write pushes DAT_I[7:0] into the TX FIFO. If TX is full the write is dropped silently.
  - 1 STATUS, read:
    - [0] rx_empty; [1] tx_full; [2] tx_idle (TX FIFO empty and TX FSM IDLE).
    - [3] overrun, sticky; [4] framing_err, sticky.
    - [15:8] rx_count.
    - Writing 1 to bit 3 or 4 clears that flag.
  - 2 CTRL, R/W: [0] rx_ie; [1] loopback (see Optional Feature). Other bits read 0.
  - 3: reads 0, writes ignored.
- FIFOs:
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Full = MSBs differ and low bits equal; empty = pointers equal.
  - Simultaneous push and pop in one cycle: both take effect and count is unchanged. This holds when full (push accepted because a pop occurs) and when empty (pop ignored, push accepted).
- RX path:
  - rxd passes through a 2-flop synchroniser.
  - IDLE: on a sampled falling edge, load the baud counter with DIV/2 and go to START.
  - START: at counter expiry, if the line is still low go to DATA with counter=DIV, else return to IDLE (glitch).
  - DATA: sample 8 bits LSB-first at each DIV expiry, then go to STOP.
  - STOP: sample once.
    - Line high: push the byte. If the RX FIFO is full, drop the byte and set overrun.
    - Line low: drop the byte and set framing_err.
    - Then go to IDLE. A new start bit may be detected the very next cycle.
- TX path:
  - IDLE: if the TX FIFO is non-empty, pop it and go to START.
  - Frame is START (txd=0), then DATA with 8 bits LSB-first, then STOP (txd=1). Each state lasts exactly DIV cycles.
  - Back-to-back bytes have no extra idle gap: STOP→START is DIV cycles per bit, 10·DIV cycles per frame.
- INT = rx_ie & ~rx_empty, registered, so it updates one cycle after the FIFO or CTRL changes.

Optional Feature:
- Macro WB_UART_LOOPBACK_EN.
- Defined: CTRL[1]=1 routes the internal TX serial output to the RX synchroniser input in place of rxd. txd is held at 1 while loopback is set; CTRL[1] is readable and writable.
- Undefined: CTRL[1] is not implemented and reads 0. The RX input is always rxd.

Test Plan (CLK_HZ=1600, BAUD=100, so DIV=16; FIFO_DEPTH=4):
- Reset, then read STATUS → ACK exactly one cycle after STB; DAT_O=0x00000005 (rx_empty, tx_idle); txd=1; INT=0.
- Write DATA=0xA5 → txd shows start(0), bits 1,0,1,0,0,1,0,1, stop(1), each exactly 16 cycles; STATUS[2] returns to 1 after 160 cycles.
- Drive serial 0x3C on rxd with CTRL=1 → INT rises after the stop sample. Read DATA returns 0x3C and INT falls next cycle; STATUS=0x05.
- Send 5 bytes 0x01..0x05 without reading → STATUS[3]=1 and rx_count=4. Reads return 0x01..0x04, then 0. Write STATUS=0x08 → bit 3 clears.
- Frame 0x55 with stop bit driven low → no push, framing_err=1. A 4-cycle low glitch on rxd → no push, no flag change.
- With WB_UART_LOOPBACK_EN and CTRL=3: write 0x5A, 0xC3 back-to-back → after 320 cycles rx_count=2, reads return 0x5A then 0xC3, txd stays 1 throughout.
